// File: rtl/stats_seq_engine.sv
// stats_seq_engine: sequences N memory reads from BASE_ADDR and produces
// max, min, sum and average of the block in one pass, with a restoring
// divider for the average and signed/unsigned compare selected per run.
module stats_seq_engine #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    SIGNED_MODE,
  input  logic [ADDR_W-1:0]       BASE_ADDR,
  input  logic [CNT_W-1:0]        COUNT,
  output logic [ADDR_W-1:0]       MEM_ADDR,
  output logic                    MEM_RD,
  input  logic [DATA_W-1:0]       MEM_DATA,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR,
  output logic [DATA_W-1:0]       MAX_OUT,
  output logic [DATA_W-1:0]       MIN_OUT,
  output logic [DATA_W+CNT_W-1:0] SUM_OUT,
  output logic [DATA_W-1:0]       AVG_OUT
);

  localparam int SUM_W  = DATA_W + CNT_W;
  localparam int DCNT_W = $clog2(SUM_W + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, DIV, FIN} state_t;

  state_t state, state_nxt;

  // control state
  logic              err_flag;
  logic              first;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        wait_cnt;
  logic [DCNT_W-1:0] div_cnt;

  // datapath state
  logic                    sgn;
  logic [CNT_W-1:0]        n_div;
  logic [DATA_W-1:0]       acc_max;
  logic [DATA_W-1:0]       acc_min;
  logic signed [SUM_W-1:0] acc_sum;
  logic [SUM_W-1:0]        quo;
  logic [CNT_W-1:0]        rem;
  logic                    neg;

  // combinational datapath results
  logic signed [SUM_W-1:0] data_ext;
  logic signed [SUM_W-1:0] sum_nxt;
  logic [DATA_W-1:0]       max_nxt;
  logic [DATA_W-1:0]       min_nxt;
  logic [CNT_W:0]          rem_sh;
  logic                    sub_ok;
  logic [CNT_W-1:0]        rem_nxt;
  logic [SUM_W-1:0]        quo_nxt;
  logic                    last_elem;
  logic                    div_last;

  // Widen an element to the accumulator width, honouring the compare mode.
  function automatic logic signed [SUM_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                      input logic s);
    return s ? {{CNT_W{d[DATA_W-1]}}, d} : {{CNT_W{1'b0}}, d};
  endfunction

  // a > b under signed or unsigned interpretation.
  function automatic logic greater(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic s);
    if (s) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Absolute value of the sum in signed mode; raw value otherwise.
  function automatic logic [SUM_W-1:0] magnitude(input logic [SUM_W-1:0] v,
                                                 input logic s);
    return (s && v[SUM_W-1]) ? -v : v;
  endfunction

  // Restore the sign of the quotient (truncation toward zero).
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] m,
                                                   input logic n);
    return n ? -m : m;
  endfunction

  // Element accumulate and one restoring-division step.
  always_comb begin
    data_ext  = extend(MEM_DATA, sgn);
    sum_nxt   = first ? data_ext : acc_sum + data_ext;
    max_nxt   = (first || greater(MEM_DATA, acc_max, sgn)) ? MEM_DATA : acc_max;
    min_nxt   = (first || greater(acc_min, MEM_DATA, sgn)) ? MEM_DATA : acc_min;
    rem_sh    = {rem, quo[SUM_W-1]};
    sub_ok    = rem_sh >= {1'b0, n_div};
    rem_nxt   = sub_ok ? CNT_W'(rem_sh - {1'b0, n_div}) : rem_sh[CNT_W-1:0];
    quo_nxt   = {quo[SUM_W-2:0], sub_ok};
    last_elem = (cnt == CNT_W'(1));
    div_last  = (div_cnt == DCNT_W'(SUM_W - 1));
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and state-decoded strobes.
  always_comb begin
    state_nxt = state;
    MEM_RD    = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    ERR       = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nxt = (COUNT == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        MEM_RD    = 1'b1;
        BUSY      = 1'b1;
        state_nxt = (MEM_LAT == 1) ? ACC : WAIT;
      end
      WAIT: begin
        BUSY = 1'b1;
        if (wait_cnt == 2'(MEM_LAT - 2)) state_nxt = ACC;
      end
      ACC: begin
        BUSY      = 1'b1;
        state_nxt = last_elem ? DIV : ISSUE;
      end
      DIV: begin
        BUSY = 1'b1;
        if (div_last) state_nxt = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        ERR       = err_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers, address sequencing and result outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      MEM_ADDR <= '0;
      MAX_OUT  <= '0;
      MIN_OUT  <= '0;
      SUM_OUT  <= '0;
      AVG_OUT  <= '0;
      err_flag <= 1'b0;
      first    <= 1'b0;
      cnt      <= '0;
      wait_cnt <= '0;
      div_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            cnt      <= COUNT;
            first    <= 1'b1;
            err_flag <= (COUNT == '0);
            if (COUNT == '0) begin
              MAX_OUT <= '0;
              MIN_OUT <= '0;
              SUM_OUT <= '0;
              AVG_OUT <= '0;
            end else begin
              MEM_ADDR <= BASE_ADDR;
            end
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT:  wait_cnt <= wait_cnt + 1'b1;
        ACC: begin
          first   <= 1'b0;
          cnt     <= cnt - 1'b1;
          div_cnt <= '0;
          if (!last_elem) MEM_ADDR <= MEM_ADDR + 1'b1;
        end
        DIV: begin
          div_cnt <= div_cnt + 1'b1;
          if (div_last) begin
            MAX_OUT <= acc_max;
            MIN_OUT <= acc_min;
            SUM_OUT <= acc_sum;
            AVG_OUT <= apply_sign(quo_nxt[DATA_W-1:0], neg);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: latched mode/count, accumulators and divider.
  always_ff @(posedge CLK) begin
    case (state)
      IDLE: begin
        if (START) begin
          sgn   <= SIGNED_MODE;
          n_div <= COUNT;
        end
      end
      ACC: begin
        acc_max <= max_nxt;
        acc_min <= min_nxt;
        acc_sum <= sum_nxt;
        if (last_elem) begin
          quo <= magnitude(sum_nxt, sgn);
          rem <= '0;
          neg <= sgn & sum_nxt[SUM_W-1];
        end
      end
      DIV: begin
        quo <= quo_nxt;
        rem <= rem_nxt;
      end
      default: ;
    endcase
  end

endmodule
